// File: rtl/dmem_responder.sv
// Single-ported data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then holds the response until the initiator takes it.
module dmem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_err
);

   localparam int         DEPTH   = 2 ** ADDR_W;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_reg, state_next;
   logic [3:0]   cnt_reg, cnt_next;
   logic         write_reg;
   logic [15:0]  addr_reg;
   logic [15:0]  wdata_reg;
   logic         err_reg;
   logic         rd_ok_reg;

   logic         accept;
   logic         enter_resp;
   logic         cur_write;
   logic [15:0]  cur_addr;
   logic [15:0]  cur_wdata;
   logic [15:0]  high_mask;
   logic         misalign;
   logic         out_of_range;
   logic         req_err;
   logic [ADDR_W-1:0] idx;
   logic         mem_we;
   logic         mem_re;

   logic [15:0]  mem [0:DEPTH-1];
   logic [15:0]  mem_q;

   // With zero wait states RESP is entered on the accept edge itself, before the
   // request registers are loaded, so the live request inputs are used there.
   assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
   assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
   assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_high_mask
         assign high_mask[gi] = (gi > ADDR_W) ? 1'b1 : 1'b0;
      end
   endgenerate

   assign misalign     = cur_addr[0];
   assign out_of_range = |(cur_addr & high_mask);
   assign req_err      = misalign | out_of_range;
   assign idx          = cur_addr[ADDR_W:1];

   assign accept = (state_reg == IDLE) && req_valid;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      enter_resp = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (WAIT_LD == 4'd0) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_LD;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               state_next = RESP;
               cnt_next   = 4'd0;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         write_reg <= 1'b0;
         addr_reg  <= 16'h0000;
         wdata_reg <= 16'h0000;
         err_reg   <= 1'b0;
         rd_ok_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            write_reg <= req_write;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
         end
         if (enter_resp) begin
            err_reg   <= req_err;
            rd_ok_reg <= ~cur_write & ~req_err;
         end
      end
   end

   // Gating with rst keeps an edge that coincides with reset from committing a store.
   assign mem_we = enter_resp & cur_write & ~req_err & ~rst;
   assign mem_re = enter_resp & ~cur_write & ~req_err & ~rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx] <= cur_wdata;
      end
      if (mem_re) begin
         mem_q <= mem[idx];
      end
   end

   assign req_ready  = (state_reg == IDLE);
   assign resp_valid = (state_reg == RESP);
   assign resp_err   = resp_valid & err_reg;
   assign resp_rdata = (resp_valid && rd_ok_reg) ? mem_q : 16'h0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-level model checks one instance every
// cycle, directed cases pin latencies and data; a zero-wait instance is checked directly.
module tb_dmem_responder;

   localparam int AW = 8;
   localparam int WA = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [15:0] resp_rdata;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [15:0] b_req_addr, b_req_wdata;
   logic        b_resp_valid, b_resp_ready, b_resp_err;
   logic [15:0] b_resp_rdata;

   dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WA)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Transaction-level model of the WAIT_CYCLES=2 instance
   bit          m_busy = 1'b0;
   int          m_due  = 0;
   bit          m_write, m_err, m_known;
   int          m_idx;
   logic [15:0] m_wdata, m_rdata;
   logic [15:0] ref_mem [int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      bit          ev;
      logic [15:0] er;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) m_busy = 1'b0;
         ev = m_busy && (cyc >= m_due);
         chk("mon_req_ready", 32'(req_ready), 32'(!m_busy));
         chk("mon_resp_valid", 32'(resp_valid), 32'(ev));
         chk("mon_resp_err", 32'(resp_err), 32'(ev && m_err));
         if (!(ev && !m_write && !m_err && !m_known)) begin
            er = (ev && !m_write && !m_err) ? m_rdata : 16'h0000;
            chk("mon_resp_rdata", 32'(resp_rdata), 32'(er));
         end
         if (ev && cyc == m_due && m_write && !m_err) ref_mem[m_idx] = m_wdata;
         if (!rst) begin
            if (ev && resp_ready) begin
               m_busy = 1'b0;
            end else if (!m_busy && req_valid) begin
               m_busy  = 1'b1;
               m_due   = cyc + WA + 1;
               m_write = req_write;
               m_err   = req_addr[0] || ((req_addr >> (AW + 1)) != 16'h0000);
               m_idx   = int'(req_addr >> 1);
               m_wdata = req_wdata;
               m_known = ref_mem.exists(m_idx);
               m_rdata = m_known ? ref_mem[m_idx] : 16'h0000;
            end
         end
      end
   endtask

   // Entered and left at the phase just after a rising edge.
   task automatic send_req(input bit w, input logic [15:0] a, input logic [15:0] d, input bit keep);
      bit ok;
      ok        = 1'b0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!keep) req_valid = 1'b0;
   endtask

   // Returns at the falling edge of the first cycle with resp_valid=1.
   task automatic wait_resp(output logic [15:0] rd, output bit er, output int lat);
      bit ok;
      ok  = 1'b0;
      lat = 0;
      rd  = 16'h0000;
      er  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin
            rd = resp_rdata;
            er = resp_err;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_txn(input string name, input bit w, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd,
                            input bit exp_er, input int exp_lat);
      logic [15:0] rd;
      bit          er;
      int          lat;
      send_req(w, a, d, 1'b0);
      wait_resp(rd, er, lat);
      @(posedge clk);
      #1;
      chk({name, "_rdata"}, 32'(rd), 32'(exp_rd));
      chk({name, "_err"}, 32'(er), 32'(exp_er));
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      $display("txn %s: write=%0d addr=%04h wdata=%04h -> rdata=%04h err=%0d latency=%0d",
               name, w, a, d, rd, er, lat);
   endtask

   // Zero-wait instance: accept in cycle n, response in n+1, ready again in n+2.
   task automatic b_txn(input string name, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd, input bit exp_er);
      b_req_valid = 1'b1;
      b_req_write = w;
      b_req_addr  = a;
      b_req_wdata = d;
      @(negedge clk);
      chk({name, "_ready_n"}, 32'(b_req_ready), 32'd1);
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      @(negedge clk);
      chk({name, "_valid_n1"}, 32'(b_resp_valid), 32'd1);
      chk({name, "_rdata_n1"}, 32'(b_resp_rdata), 32'(exp_rd));
      chk({name, "_err_n1"}, 32'(b_resp_err), 32'(exp_er));
      chk({name, "_ready_n1"}, 32'(b_req_ready), 32'd0);
      @(negedge clk);
      chk({name, "_ready_n2"}, 32'(b_req_ready), 32'd1);
      chk({name, "_valid_n2"}, 32'(b_resp_valid), 32'd0);
      $display("w0 txn %s: write=%0d addr=%04h -> rdata=%04h err=%0d", name, w, a, b_resp_rdata, b_resp_err);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] rd;
      bit          er;
      int          lat;

      req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; resp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'h0; b_req_wdata = 16'h0; b_resp_ready = 1'b1;

      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_w0_req_ready", 32'(b_req_ready), 32'd1);
      chk("rst_w0_resp_valid", 32'(b_resp_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Store then load, read-after-write
      check_txn("st_0010", 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 3);
      check_txn("ld_0010", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3);
      check_txn("st_0000", 1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b0, 3);
      check_txn("ld_0000", 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 3);
      check_txn("st_01fe", 1'b1, 16'h01FE, 16'hCAFE, 16'h0000, 1'b0, 3);
      check_txn("ld_01fe", 1'b0, 16'h01FE, 16'h0000, 16'hCAFE, 1'b0, 3);

      // Error requests
      check_txn("st_mis_0011", 1'b1, 16'h0011, 16'h9999, 16'h0000, 1'b1, 3);
      check_txn("ld_0010_again", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3);
      check_txn("ld_oor_0400", 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 3);
      check_txn("ld_oor_0200", 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1, 3);
      check_txn("ld_mis_0013", 1'b0, 16'h0013, 16'h0000, 16'h0000, 1'b1, 3);
      check_txn("st_oor_8000", 1'b1, 16'h8000, 16'h5555, 16'h0000, 1'b1, 3);
      check_txn("ld_0000_after_oor", 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 3);

      // Response stall for 5 cycles
      resp_ready = 1'b0;
      send_req(1'b0, 16'h0010, 16'h0000, 1'b0);
      wait_resp(rd, er, lat);
      chk("stall_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_rdata", 32'(resp_rdata), 32'hBEEF);
         chk("stall_err", 32'(resp_err), 32'd0);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", 32'(resp_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("release_idle_ready", 32'(req_ready), 32'd1);
      chk("release_idle_valid", 32'(resp_valid), 32'd0);
      $display("stall: rdata=%04h held 5 cycles, released", rd);
      @(posedge clk);
      #1;

      // Reset one cycle after a store is accepted
      check_txn("st_0020_pre", 1'b1, 16'h0020, 16'hAAAA, 16'h0000, 1'b0, 3);
      send_req(1'b1, 16'h0020, 16'h1234, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midwait_rst_ready", 32'(req_ready), 32'd1);
      chk("midwait_rst_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midwait_no_resp", 32'(resp_valid), 32'd0);
      end
      $display("reset mid-wait: store 0020 aborted");
      @(posedge clk);
      #1;
      check_txn("ld_0020_after_rst", 1'b0, 16'h0020, 16'h0000, 16'hAAAA, 1'b0, 3);

      // New request held during WAIT/RESP must be ignored
      check_txn("st_0042_pre", 1'b1, 16'h0042, 16'h7777, 16'h0000, 1'b0, 3);
      send_req(1'b1, 16'h0040, 16'h1111, 1'b1);
      req_addr  = 16'h0042;
      req_wdata = 16'h2222;
      wait_resp(rd, er, lat);
      chk("held_req_latency", 32'(lat), 32'd3);
      chk("held_req_err", 32'(er), 32'd0);
      chk("held_req_rdata", 32'(rd), 32'd0);
      $display("held request during wait: first response err=%0d latency=%0d", er, lat);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_txn("ld_0040", 1'b0, 16'h0040, 16'h0000, 16'h1111, 1'b0, 3);
      check_txn("ld_0042", 1'b0, 16'h0042, 16'h0000, 16'h7777, 1'b0, 3);

      // Zero wait states, back-to-back
      b_txn("w0_st_0030", 1'b1, 16'h0030, 16'h5A5A, 16'h0000, 1'b0);
      b_txn("w0_ld_0030", 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1'b0);
      b_txn("w0_ld_mis", 1'b0, 16'h0031, 16'h0000, 16'h0000, 1'b1);
      b_txn("w0_ld_oor", 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
